// File: rtl/cam_capture_ctrl.sv
// Camera frame-capture sequencer: synchronizes PCLK/HREF/VSYNC and issues byte strobes, pixel writes and addresses.
// Optional overrun flag built only when CAM_CAPTURE_CTRL_ERR_EN is defined.
module cam_capture_ctrl #(
    parameter int unsigned IMG_W = 160,
    parameter int unsigned IMG_H = 120,
    parameter int unsigned AW    = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          continuous_i,
    input  logic          cam_pclk_i,
    input  logic          cam_href_i,
    input  logic          cam_vsync_i,
    output logic          byte_stb_o,
    output logic          byte_sel_o,
    output logic          cap_we_o,
    output logic [AW-1:0] cap_addr_o,
    output logic          busy_o,
    output logic          frame_done_o,
    output logic          err_overrun_o
);
    localparam int unsigned PXW = $clog2(IMG_W + 1);
    localparam int unsigned LNW = $clog2(IMG_H + 1);
    localparam logic [PXW-1:0] PX_MAX    = PXW'(IMG_W);
    localparam logic [LNW-1:0] LN_MAX    = LNW'(IMG_H);
    localparam logic [AW-1:0]  LINE_STEP = AW'(IMG_W);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_WAIT_SOF, S_CAPTURE, S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [2:0]     pclk_q;
    logic [1:0]     href_q, vsync_q;
    logic           href_smp_q, vsync_smp_q;
    logic           pclk_edge, href_fall, vsync_fall, vsync_rise, in_range;

    logic [PXW-1:0] px_q, px_d;
    logic [LNW-1:0] line_q, line_d;
    logic [AW-1:0]  base_q, base_d;
    logic           phase_q, phase_d;
    logic           byte_stb_q, byte_stb_d, byte_sel_q, byte_sel_d;
    logic           cap_we_q, cap_we_d, busy_q, busy_d, frame_done_q, frame_done_d;
    logic [AW-1:0]  cap_addr_q, cap_addr_d;

    // Two-flop synchronizers; pclk_q[2] is the previous synchronized PCLK for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pclk_q      <= '0;
            href_q      <= '0;
            vsync_q     <= '0;
            href_smp_q  <= 1'b0;
            vsync_smp_q <= 1'b0;
        end else begin
            pclk_q  <= {pclk_q[1:0], cam_pclk_i};
            href_q  <= {href_q[0], cam_href_i};
            vsync_q <= {vsync_q[0], cam_vsync_i};
            if (pclk_edge) begin
                href_smp_q  <= href_q[1];
                vsync_smp_q <= vsync_q[1];
            end
        end
    end

    assign pclk_edge  = pclk_q[1] & ~pclk_q[2];
    assign href_fall  = pclk_edge & href_smp_q & ~href_q[1];
    assign vsync_fall = pclk_edge & vsync_smp_q & ~vsync_q[1];
    assign vsync_rise = pclk_edge & ~vsync_smp_q & vsync_q[1];
    assign in_range   = (px_q < PX_MAX) && (line_q < LN_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (start_i || continuous_i) state_d = S_ARM;
            S_ARM:      if (vsync_q[1]) state_d = S_WAIT_SOF;
            S_WAIT_SOF: if (vsync_fall) state_d = S_CAPTURE;
            S_CAPTURE:  if (vsync_rise) state_d = S_DONE;
            S_DONE:     state_d = continuous_i ? S_WAIT_SOF : S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Counters and registered outputs; line_base stops advancing once line_idx reaches IMG_H
    always_comb begin
        px_d         = px_q;
        line_d       = line_q;
        base_d       = base_q;
        phase_d      = phase_q;
        byte_stb_d   = 1'b0;
        byte_sel_d   = byte_sel_q;
        cap_we_d     = 1'b0;
        cap_addr_d   = cap_addr_q;
        frame_done_d = 1'b0;
        busy_d       = (state_d != S_IDLE) && !(state_d == S_DONE && !continuous_i);
        unique case (state_q)
            S_WAIT_SOF: begin
                if (vsync_fall) begin
                    px_d    = '0;
                    line_d  = '0;
                    base_d  = '0;
                    phase_d = 1'b0;
                end
            end
            S_CAPTURE: begin
                if (vsync_rise) begin
                    frame_done_d = 1'b1;
                end else if (pclk_edge && href_q[1]) begin
                    byte_stb_d = 1'b1;
                    byte_sel_d = phase_q;
                    if (phase_q) begin
                        if (in_range) begin
                            cap_we_d   = 1'b1;
                            cap_addr_d = base_q + AW'(px_q);
                        end
                        if (px_q < PX_MAX) px_d = px_q + PXW'(1);
                    end
                    phase_d = ~phase_q;
                end else if (href_fall) begin
                    px_d    = '0;
                    phase_d = 1'b0;
                    if (line_q < LN_MAX) begin
                        line_d = line_q + LNW'(1);
                        base_d = base_q + LINE_STEP;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_q         <= '0;
            line_q       <= '0;
            base_q       <= '0;
            phase_q      <= 1'b0;
            byte_stb_q   <= 1'b0;
            byte_sel_q   <= 1'b0;
            cap_we_q     <= 1'b0;
            cap_addr_q   <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            px_q         <= px_d;
            line_q       <= line_d;
            base_q       <= base_d;
            phase_q      <= phase_d;
            byte_stb_q   <= byte_stb_d;
            byte_sel_q   <= byte_sel_d;
            cap_we_q     <= cap_we_d;
            cap_addr_q   <= cap_addr_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign byte_stb_o   = byte_stb_q;
    assign byte_sel_o   = byte_sel_q;
    assign cap_we_o     = cap_we_q;
    assign cap_addr_o   = cap_addr_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;

`ifdef CAM_CAPTURE_CTRL_ERR_EN
    logic err_q, err_d, clamp_hit;

    // A second-byte strobe whose pixel falls outside the buffer is an overrun
    assign clamp_hit = (state_q == S_CAPTURE) && pclk_edge && !vsync_rise
                       && href_q[1] && phase_q && !in_range;

    always_comb begin
        err_d = err_q;
        if (state_q == S_IDLE && start_i) err_d = 1'b0;
        else if (clamp_hit)               err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err_overrun_o = err_q;
`else
    assign err_overrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Bench for cam_capture_ctrl: behavioural camera, address scoreboard, one task per scenario.
module tb_cam_capture_ctrl;
    localparam int unsigned IMG_W = 4;
    localparam int unsigned IMG_H = 3;
    localparam int unsigned AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic          pclk = 1'b0;
    logic          href = 1'b0;
    logic          vsync = 1'b0;
    logic          byte_stb, byte_sel, cap_we, busy, frame_done, err_overrun;
    logic [AW-1:0] cap_addr;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int fd_cnt = 0;
    int stb_cnt = 0;
    bit sb_en = 1'b1;
    logic [AW-1:0] exp_q[$];

    int std_b[4]   = '{8, 8, 8, 0};
    int clamp_b[4] = '{10, 10, 10, 8};
    int short_b[4] = '{6, 8, 0, 0};

    cam_capture_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .continuous_i(continuous),
        .cam_pclk_i(pclk), .cam_href_i(href), .cam_vsync_i(vsync),
        .byte_stb_o(byte_stb), .byte_sel_o(byte_sel), .cap_we_o(cap_we),
        .cap_addr_o(cap_addr), .busy_o(busy), .frame_done_o(frame_done),
        .err_overrun_o(err_overrun)
    );

    always #5 clk = ~clk;

    // One camera PCLK period (4 system clocks); HREF/VSYNC change while PCLK is low
    task automatic cam_pclk(input logic h, input logic v);
        pclk = 1'b0; href = h; vsync = v;
        #20;
        pclk = 1'b1;
        #20;
    endtask

    task automatic cam_vblank(input int n);
        repeat (n) cam_pclk(1'b0, 1'b1);
    endtask

    task automatic cam_frame(input int nlines, input int nbytes[4]);
        cam_vblank(4);
        repeat (2) cam_pclk(1'b0, 1'b0);
        for (int l = 0; l < nlines; l++) begin
            repeat (2) cam_pclk(1'b0, 1'b0);
            for (int b = 0; b < nbytes[l]; b++) cam_pclk(1'b1, 1'b0);
            repeat (2) cam_pclk(1'b0, 1'b0);
        end
    endtask

    task automatic sb_push_frame(input int nlines, input int nbytes[4]);
        for (int l = 0; l < nlines; l++)
            for (int p = 0; p < nbytes[l] / 2; p++)
                if (p < int'(IMG_W) && l < int'(IMG_H)) exp_q.push_back(AW'(l * int'(IMG_W) + p));
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic [AW-1:0] exp_a;
        forever begin
            @(negedge clk);
            if (byte_stb) stb_cnt++;
            if (frame_done) fd_cnt++;
            if (cap_we) begin
                wr_cnt++;
                checks++;
                if (!(byte_stb && byte_sel)) begin
                    errors++;
                    $display("FAIL we_phase: cap_we with byte_stb=%0b byte_sel=%0b, need both 1", byte_stb, byte_sel);
                end
                if (sb_en) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: addr %0d written, no write expected", cap_addr);
                    end else begin
                        exp_a = exp_q.pop_front();
                        if (cap_addr !== exp_a) begin
                            errors++;
                            $display("FAIL cap_addr: got %0d expected %0d", cap_addr, exp_a);
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_writes: %0d expected writes never seen, need 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (byte_stb !== 1'b0)   begin errors++; $display("FAIL rst_byte_stb: got %b expected 0", byte_stb); end
        checks++; if (byte_sel !== 1'b0)   begin errors++; $display("FAIL rst_byte_sel: got %b expected 0", byte_sel); end
        checks++; if (cap_we !== 1'b0)     begin errors++; $display("FAIL rst_cap_we: got %b expected 0", cap_we); end
        checks++; if (cap_addr !== '0)     begin errors++; $display("FAIL rst_cap_addr: got %0d expected 0", cap_addr); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b expected 0", frame_done); end
        checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err_overrun); end
        rst_n = 1'b1;
        settle();
    endtask

    task automatic test_single_frame();
        int w0 = wr_cnt, f0 = fd_cnt, s0 = stb_cnt;
        fork
            cam_frame(3, std_b);
            begin
                #900;
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_before_start: got %b expected 0", busy); end
                pulse_start();
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_rise: got %b expected 1", busy); end
            end
        join
        sb_push_frame(3, std_b);
        cam_frame(3, std_b);
        cam_vblank(4);
        settle();
        check_queue_empty("single");
        checks++; if (wr_cnt - w0 != 12)   begin errors++; $display("FAIL single_writes: got %0d expected 12", wr_cnt - w0); end
        checks++; if (stb_cnt - s0 != 24)  begin errors++; $display("FAIL single_strobes: got %0d expected 24", stb_cnt - s0); end
        checks++; if (fd_cnt - f0 != 1)    begin errors++; $display("FAIL single_frame_done: got %0d expected 1", fd_cnt - f0); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy); end
        checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", err_overrun); end
    endtask

    task automatic test_continuous();
        int w0 = wr_cnt, f0 = fd_cnt;
        @(posedge clk); #1 continuous = 1'b1;
        sb_push_frame(3, std_b);
        cam_frame(3, std_b);
        sb_push_frame(3, std_b);
        cam_frame(3, std_b);
        sb_push_frame(3, std_b);
        fork
            cam_frame(3, std_b);
            begin #600; @(posedge clk); #1 continuous = 1'b0; end
        join
        cam_vblank(4);
        settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_busy_after: got %b expected 0", busy); end
        cam_frame(3, std_b);
        cam_vblank(4);
        settle();
        check_queue_empty("cont");
        checks++; if (wr_cnt - w0 != 36) begin errors++; $display("FAIL cont_writes: got %0d expected 36", wr_cnt - w0); end
        checks++; if (fd_cnt - f0 != 3)  begin errors++; $display("FAIL cont_frame_done: got %0d expected 3", fd_cnt - f0); end
    endtask

    task automatic test_clamp();
        int s0 = stb_cnt, f0 = fd_cnt;
        logic exp_err;
`ifdef CAM_CAPTURE_CTRL_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        pulse_start();
        sb_push_frame(4, clamp_b);
        cam_frame(4, clamp_b);
        cam_vblank(4);
        settle();
        check_queue_empty("clamp");
        checks++; if (stb_cnt - s0 != 38) begin errors++; $display("FAIL clamp_strobes: got %0d expected 38", stb_cnt - s0); end
        checks++; if (fd_cnt - f0 != 1)   begin errors++; $display("FAIL clamp_frame_done: got %0d expected 1", fd_cnt - f0); end
        checks++; if (err_overrun !== exp_err) begin errors++; $display("FAIL clamp_err: got %b expected %b", err_overrun, exp_err); end
    endtask

    task automatic test_short();
        int f0 = fd_cnt;
        pulse_start();
        checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL err_clear_on_start: got %b expected 0", err_overrun); end
        sb_push_frame(2, short_b);
        cam_frame(2, short_b);
        cam_vblank(4);
        settle();
        check_queue_empty("short");
        checks++; if (fd_cnt - f0 != 1)     begin errors++; $display("FAIL short_frame_done: got %0d expected 1", fd_cnt - f0); end
        checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL short_err: got %b expected 0", err_overrun); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL short_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        int f0 = fd_cnt, w0 = wr_cnt;
        pulse_start();
        sb_en = 1'b0;
        fork
            cam_frame(3, std_b);
            begin
                int n = 0;
                while (wr_cnt < w0 + 5 && n < 1000) begin @(posedge clk); n++; end
                checks++; if (n >= 1000) begin errors++; $display("FAIL rstmid_timeout: got %0d writes expected 5", wr_cnt - w0); end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
                @(posedge clk); #1 rst_n = 1'b0;
                #1;
                checks++;
                if ({byte_stb, byte_sel, cap_we, cap_addr, busy, frame_done, err_overrun} !== '0) begin
                    errors++;
                    $display("FAIL rstmid_outputs: got stb=%b sel=%b we=%b addr=%0d busy=%b fd=%b err=%b expected all 0",
                             byte_stb, byte_sel, cap_we, cap_addr, busy, frame_done, err_overrun);
                end
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        join
        exp_q.delete();
        sb_en = 1'b1;
        cam_frame(3, std_b);
        pulse_start();
        sb_push_frame(3, std_b);
        cam_frame(3, std_b);
        cam_vblank(4);
        settle();
        check_queue_empty("rstmid");
        checks++; if (fd_cnt - f0 != 1) begin errors++; $display("FAIL rstmid_frame_done: got %0d expected 1", fd_cnt - f0); end
    endtask

    task automatic test_busy_start();
        int w0 = wr_cnt, f0 = fd_cnt;
        pulse_start();
        sb_push_frame(3, std_b);
        fork
            cam_frame(3, std_b);
            begin
                #900;
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid_frame: got %b expected 1", busy); end
                pulse_start();
            end
        join
        cam_vblank(4);
        settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busystart_busy_after: got %b expected 0", busy); end
        cam_frame(3, std_b);
        cam_vblank(4);
        settle();
        check_queue_empty("busystart");
        checks++; if (wr_cnt - w0 != 12) begin errors++; $display("FAIL busystart_writes: got %0d expected 12", wr_cnt - w0); end
        checks++; if (fd_cnt - f0 != 1)  begin errors++; $display("FAIL busystart_frame_done: got %0d expected 1", fd_cnt - f0); end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single_frame();
        test_continuous();
        test_clamp();
        test_short();
        test_reset_mid();
        test_busy_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
